ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Fetch-stage producer for the next-PC logic.
- Holds the architectural PC and issues word fetches to instruction memory over a req/ready + rvalid handshake.
- Delivers {instr, pc, pc4} through the IF/ID register to decode, where next-PC logic consumes pc4/instr.
- Accepts the computed next PC back as a redirect, with MIPS delayed-branch semantics (the delay-slot fetch always completes).

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, bubble word placed in IF/ID on flush or empty.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- stall  in  1  hazard unit: hold IF/ID and PC
- redirect  in  1  decode selected a non-sequential next PC (taken branch, j, jal, jr)
- npc_in  in  32  redirect target, valid when redirect=1
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address (= pc)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  fetched instruction
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  IF/ID PC
- id_pc4  out  32  IF/ID PC+4
- id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (reset=0 at edge):
  - pc=RESET_PC; state=REQ; imem_req=0 that cycle.
  - id_instr=NOP_INSTR, id_pc=0, id_pc4=0, id_valid=0.
  - Redirect buffer cleared; discard flag cleared.
  - Reset during WAIT: the in-flight response is dropped via the discard flag, which is set on reset exit if rvalid is still owed.
- FSM states REQ, WAIT, HOLD:
  - REQ: imem_req=1, imem_addr=pc. On imem_ready go to WAIT; otherwise stay in REQ with address stable.
  - WAIT: imem_req=0. On imem_rvalid:
    - If stall=0: load IF/ID ({rdata, pc, pc+4}, id_valid=1), advance pc, go to REQ.
    - If stall=1: capture rdata in a skid register and go to HOLD.
  - HOLD: when stall drops, load IF/ID from the skid register, advance pc, go to REQ.
- PC advance: pc_next = redirect_pending ? target_buf : pc+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0). Using target_buf clears redirect_pending.
- Redirect handling:
  - redirect=1 with stall=0 latches npc_in into target_buf and sets redirect_pending.
  - It applies to the fetch after the current one (the delay slot), so the delay slot is never killed.
  - A second redirect while one is pending overwrites target_buf.
  - redirect with stall=1 is ignored; decode re-asserts it.
- Decode with no new fetch: if fetch is not complete and stall=0, IF/ID loads a bubble (NOP_INSTR, id_valid=0).
- Latency and stability:
  - Zero-wait memory (ready=1, rvalid the next cycle): one instruction every 2 cycles. Pipelined throughput is out of scope.
  - stall=1 freezes IF/ID outputs and pc unchanged.
- imem_rvalid outside WAIT is a protocol error and is ignored.

Optional Feature:
- Macro IFU_ALIGN_CHECK_EN.
- When defined:
  - Adds output id_adel (1 bit).
  - A redirect target with npc_in[1:0]!=0 is not fetched. IF/ID loads NOP_INSTR with id_valid=1, id_adel=1, id_pc=bad target, and pc is forced to bad target+4.
- When undefined:
  - id_adel is absent.
  - npc_in[1:0] is forced to 2'b00 before latching.

Decomposition:
- Shared package: RESET_PC and NOP_INSTR defaults, FSM state encoding (REQ/WAIT/HOLD), word-size constant 4.
- One natural sub-module: if_id_reg (stall/bubble-capable pipeline register holding instr/pc/pc4/valid). The FSM and PC logic stay in ifu_fetch.

Test Plan:
- Reset, ready=1, rvalid the cycle after the request, rdata=32'h2408_0001: first imem_addr=32'h3000 → id_pc=32'h3000, id_pc4=32'h3004, id_instr=32'h2408_0001, id_valid=1; next imem_addr=32'h3004.
- Redirect to npc_in=32'h3040 asserted while the 32'h3008 fetch is in WAIT → 32'h3008 (delay slot) reaches IF/ID; next imem_addr=32'h3040.
- Hold imem_ready=0 for 5 cycles at pc=32'h300C → imem_req stays 1, imem_addr stable at 32'h300C, IF/ID shows bubbles (id_valid=0).
- rvalid arrives with stall=1 for 3 cycles → IF/ID unchanged; state HOLD; on stall release, the captured word appears in IF/ID exactly once and pc advances by 4.
- reset=0 asserted during WAIT, late rvalid arrives after release → late word discarded; first IF/ID instruction has id_pc=32'h3000.
- With IFU_ALIGN_CHECK_EN, redirect npc_in=32'h3042 → id_adel=1, id_pc=32'h3042, id_instr=0; next imem_addr=32'h3046 not issued as the 32'h3042 fetch; without the macro, imem_addr=32'h3040.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared constants and FSM encoding for the fetch stage
package ifu_fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES    = 32'd4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifu_fetch_if_id_reg.sv
// rtl/ifu_fetch_if_id_reg.sv - IF/ID pipeline register with stall hold and bubble insertion
// Optional IFU_ALIGN_CHECK_EN adds the address-error flag.
module ifu_fetch_if_id_reg
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
`ifdef IFU_ALIGN_CHECK_EN
  input  logic        adel,
  output logic        id_adel,
`endif
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      id_adel  <= 1'b0;
`endif
    end else if (!stall) begin
      if (load) begin
        id_instr <= instr;
        id_pc    <= pc;
        id_pc4   <= pc4;
        id_valid <= 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
        id_adel  <= adel;
`endif
      end else begin
        // Bubble keeps the last pc/pc4 so only the instruction and valid move.
        id_instr <= NOP_INSTR;
        id_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        id_adel  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch stage: PC, imem handshake FSM, delayed-branch redirect
// Optional IFU_ALIGN_CHECK_EN flags misaligned redirect targets instead of fetching them.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] npc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
`ifdef IFU_ALIGN_CHECK_EN
  output logic        id_adel,
`endif
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  fetch_state_t state;
  logic [31:0]  pc, target_buf, skid;
  logic         redirect_pending, discard, adel_pend;
  logic         take_redirect, eff_pending, fetch_done, req_int, bad_target;
  logic [31:0]  npc_m, eff_target, advance_pc, load_instr;

`ifdef IFU_ALIGN_CHECK_EN
  assign npc_m = npc_in;
`else
  assign npc_m = npc_in & ~32'd3;
  assign adel_pend = 1'b0;
`endif

  assign take_redirect = redirect & ~stall;
  // Same-cycle redirect bypasses the buffer so it still targets the fetch after this one.
  assign eff_pending   = take_redirect | redirect_pending;
  assign eff_target    = take_redirect ? npc_m : target_buf;
  assign advance_pc    = eff_pending ? eff_target : pc + WORD_BYTES;
  assign bad_target    = eff_pending & (eff_target[1:0] != 2'b00);

  assign req_int   = (state == ST_REQ) & ~discard & ~adel_pend;
  assign imem_req  = reset & req_int;
  assign imem_addr = pc;

  always_comb begin
    fetch_done = 1'b0;
    load_instr = imem_rdata;
    if (!stall) begin
      case (state)
        ST_WAIT: fetch_done = imem_rvalid;
        ST_HOLD: begin
          fetch_done = 1'b1;
          load_instr = skid;
        end
        default: begin
          fetch_done = adel_pend;
          load_instr = NOP_INSTR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc               <= RESET_PC;
      state            <= ST_REQ;
      target_buf       <= '0;
      redirect_pending <= 1'b0;
      skid             <= NOP_INSTR;
      // A response still owed from before reset must be swallowed after release.
      discard          <= ((state == ST_WAIT) | discard) & ~imem_rvalid;
`ifdef IFU_ALIGN_CHECK_EN
      adel_pend        <= 1'b0;
`endif
    end else begin
      if (fetch_done) begin
        pc               <= advance_pc;
        redirect_pending <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        adel_pend        <= bad_target;
`endif
      end else if (take_redirect) begin
        target_buf       <= npc_m;
        redirect_pending <= 1'b1;
      end
      case (state)
        ST_REQ: begin
          if (discard && imem_rvalid) discard <= 1'b0;
          if (req_int && imem_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (stall) begin
              skid  <= imem_rdata;
              state <= ST_HOLD;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_HOLD: if (!stall) state <= ST_REQ;
        default: state <= ST_REQ;
      endcase
    end
  end

  ifu_fetch_if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .load     (fetch_done),
    .instr    (load_instr),
    .pc       (pc),
    .pc4      (pc + WORD_BYTES),
`ifdef IFU_ALIGN_CHECK_EN
    .adel     (adel_pend),
    .id_adel  (id_adel),
`endif
    .id_instr (id_instr),
    .id_pc    (id_pc),
    .id_pc4   (id_pc4),
    .id_valid (id_valid)
  );

`ifndef IFU_ALIGN_CHECK_EN
  logic unused_ok;
  assign unused_ok = bad_target;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed bench for ifu_fetch (IFU_ALIGN_CHECK_EN aware)
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] npc_in = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] id_instr, id_pc, id_pc4;
  logic        id_valid;
`ifdef IFU_ALIGN_CHECK_EN
  logic        id_adel;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic        owed = 1'b0;
  logic [31:0] owed_addr = '0;
  logic        hold_rsp = 1'b0;

  ifu_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .npc_in      (npc_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
`ifdef IFU_ALIGN_CHECK_EN
    .id_adel     (id_adel),
`endif
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h3000) ? 32'h2408_0001 : {8'hA5, a[23:0]};
  endfunction

  // Memory model: response one cycle after acceptance unless held back.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (owed && !hold_rsp) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(owed_addr);
      owed        = 1'b0;
    end
    if (imem_req && imem_ready) begin
      owed      = 1'b1;
      owed_addr = imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (id_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    vectors++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0 || id_pc4 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state got req=%b valid=%b instr=%h pc=%h pc4=%h want 0 0 0 0 0",
               imem_req, id_valid, id_instr, id_pc, id_pc4);
    end
  endtask

  task automatic test_first_fetch();
    bit ok;
    reset = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      miscompares++;
      $display("FAIL first_req got req=%b addr=%h want 1 3000", imem_req, imem_addr);
    end
    wait_valid(ok);
    vectors++;
    if (!ok || id_pc !== 32'h3000 || id_pc4 !== 32'h3004 || id_instr !== 32'h2408_0001) begin
      miscompares++;
      $display("FAIL first_ifid got ok=%b pc=%h pc4=%h instr=%h want 1 3000 3004 24080001",
               ok, id_pc, id_pc4, id_instr);
    end
    vectors++;
    if (imem_addr !== 32'h3004 || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL next_addr got req=%b addr=%h want 1 3004", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    wait_valid(ok);
    vectors++;
    if (!ok || id_pc !== 32'h3004) begin
      miscompares++;
      $display("FAIL seq_3004 got ok=%b pc=%h want 1 3004", ok, id_pc);
    end
    tick();
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_req got %b want 0", imem_req);
    end
    redirect = 1'b1;
    npc_in   = 32'h3040;
    tick();
    redirect = 1'b0;
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h3008 || id_instr !== mem_word(32'h3008) || imem_addr !== 32'h3040) begin
      miscompares++;
      $display("FAIL delay_slot got valid=%b pc=%h instr=%h addr=%h want 1 3008 %h 3040",
               id_valid, id_pc, id_instr, imem_addr, mem_word(32'h3008));
    end
    wait_valid(ok);
    vectors++;
    if (!ok || id_pc !== 32'h3040 || id_pc4 !== 32'h3044) begin
      miscompares++;
      $display("FAIL target_fetch got ok=%b pc=%h pc4=%h want 1 3040 3044", ok, id_pc, id_pc4);
    end
  endtask

  task automatic test_ready_low();
    bit ok;
    do_reset();
    for (int k = 0; k < 3; k++) wait_valid(ok);
    vectors++;
    if (!ok || id_pc !== 32'h3008) begin
      miscompares++;
      $display("FAIL reach_3008 got ok=%b pc=%h want 1 3008", ok, id_pc);
    end
    imem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h300C || id_valid !== 1'b0 || id_instr !== 32'h0) begin
        miscompares++;
        $display("FAIL ready_low cyc=%0d got req=%b addr=%h valid=%b instr=%h want 1 300c 0 0",
                 c, imem_req, imem_addr, id_valid, id_instr);
      end
    end
    imem_ready = 1'b1;
    wait_valid(ok);
    vectors++;
    if (!ok || id_pc !== 32'h300C) begin
      miscompares++;
      $display("FAIL after_ready got ok=%b pc=%h want 1 300c", ok, id_pc);
    end
  endtask

  task automatic test_stall_hold();
    tick();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h300C || imem_req !== 1'b0 || imem_addr !== 32'h3010) begin
        miscompares++;
        $display("FAIL stall_hold cyc=%0d got valid=%b instr=%h pc=%h req=%b addr=%h want 0 0 300c 0 3010",
                 c, id_valid, id_instr, id_pc, imem_req, imem_addr);
      end
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h3010 || id_instr !== mem_word(32'h3010) || imem_addr !== 32'h3014) begin
      miscompares++;
      $display("FAIL skid_release got valid=%b pc=%h instr=%h addr=%h want 1 3010 %h 3014",
               id_valid, id_pc, id_instr, imem_addr, mem_word(32'h3010));
    end
    tick();
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL skid_once got valid=%b want 0", id_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    hold_rsp = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL discard_req got %b want 0", imem_req);
    end
    hold_rsp = 1'b0;
    tick();
    vectors++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      miscompares++;
      $display("FAIL late_drop got valid=%b req=%b addr=%h want 0 1 3000", id_valid, imem_req, imem_addr);
    end
    wait_valid(ok);
    vectors++;
    if (!ok || id_pc !== 32'h3000 || id_instr !== 32'h2408_0001) begin
      miscompares++;
      $display("FAIL post_reset_first got ok=%b pc=%h instr=%h want 1 3000 24080001", ok, id_pc, id_instr);
    end
  endtask

  task automatic test_misalign();
    bit ok;
    do_reset();
    wait_valid(ok);
    tick();
    redirect = 1'b1;
    npc_in   = 32'h3042;
    tick();
    redirect = 1'b0;
    vectors++;
    if (id_pc !== 32'h3004 || id_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_slot got pc=%h valid=%b want 3004 1", id_pc, id_valid);
    end
`ifdef IFU_ALIGN_CHECK_EN
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h3042) begin
      miscompares++;
      $display("FAIL adel_noreq got req=%b addr=%h want 0 3042", imem_req, imem_addr);
    end
    tick();
    vectors++;
    if (id_adel !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h3042 || id_pc4 !== 32'h3046 ||
        id_instr !== 32'h0 || imem_addr !== 32'h3046) begin
      miscompares++;
      $display("FAIL adel_entry got adel=%b valid=%b pc=%h pc4=%h instr=%h addr=%h want 1 1 3042 3046 0 3046",
               id_adel, id_valid, id_pc, id_pc4, id_instr, imem_addr);
    end
`else
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3040) begin
      miscompares++;
      $display("FAIL misalign_mask got req=%b addr=%h want 1 3040", imem_req, imem_addr);
    end
`endif
  endtask

  task automatic test_overwrite_wrap();
    bit ok;
    do_reset();
    wait_valid(ok);
    tick();
    hold_rsp = 1'b1;
    redirect = 1'b1;
    npc_in   = 32'h3100;
    tick();
    npc_in   = 32'hFFFF_FFFC;
    tick();
    stall    = 1'b1;
    npc_in   = 32'h3200;
    tick();
    stall    = 1'b0;
    redirect = 1'b0;
    hold_rsp = 1'b0;
    tick();
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h3004 || imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL redirect_overwrite got valid=%b pc=%h addr=%h want 1 3004 fffffffc",
               id_valid, id_pc, imem_addr);
    end
    wait_valid(ok);
    vectors++;
    if (!ok || id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL pc_wrap got ok=%b pc=%h pc4=%h addr=%h want 1 fffffffc 0 0",
               ok, id_pc, id_pc4, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_redirect();
    test_ready_low();
    test_stall_hold();
    test_reset_in_wait();
    test_misalign();
    test_overwrite_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
